// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
//   Controls the EX-stage operand path of the RV32IC pipeline.
//   - Computes the forwardA/forwardB selects from the instruction in decode and
//     registers them, so they are valid when that instruction reaches EX.
//   - Detects load-use hazards and inserts bubbles; flushes IF/ID and ID/EX on
//     taken branches; freezes everything while memory is busy.
//   - Keeps saturating stall/flush event counters for performance debug.
// Ports
//   i_clk, i_rst          clock (rising edge), synchronous active-low reset
//   i_mem_busy            memory busy: freeze the whole pipeline
//   i_id_rs1/2, i_id_use_rs1/2    sources of the IF/ID instruction and their use flags
//   i_ex_rd, i_ex_regwrite, i_ex_memread   destination/kind of the ID/EX instruction
//   i_mem_rd, i_mem_regwrite      destination of the EX/MEM instruction
//   i_ex_branch_taken     branch/jump in EX resolved taken
//   o_forwardA/B          registered operand selects (00 RF, 10 EX/MEM, 01 MEM/WB)
//   o_stall_pc, o_bubble_id_ex, o_flush_if_id, o_flush_id_ex   same-cycle controls
//   o_stall_cnt, o_flush_cnt     saturating event counters
module hazard_fwd_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mem_busy,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_regwrite,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mem_regwrite,
  input  logic             i_ex_branch_taken,
  output logic [1:0]       o_forwardA,
  output logic [1:0]       o_forwardB,
  output logic             o_stall_pc,
  output logic             o_bubble_id_ex,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

  localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_lu;
  logic       w_stall_pc;
  logic       w_bubble;
  logic       w_flush;

  // A load in EX cannot forward yet (data not available until MEM), so it
  // is excluded from the EX match and handled as a load-use hazard instead.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && i_ex_regwrite && i_ex_rd != 5'd0 && i_ex_rd == rs && !i_ex_memread)
      sel = 2'b10;
    else if (use_rs && i_mem_regwrite && i_mem_rd != 5'd0 && i_mem_rd == rs)
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    w_sel_a = fwd_sel(i_id_rs1, i_id_use_rs1);
    w_sel_b = fwd_sel(i_id_rs2, i_id_use_rs2);
    w_lu    = i_ex_memread && i_ex_rd != 5'd0 &&
              ((i_id_use_rs1 && i_ex_rd == i_id_rs1) ||
               (i_id_use_rs2 && i_ex_rd == i_id_rs2));
  end

  // Same-cycle controls. mem_busy wins over everything except reset;
  // a taken branch wins over any stall.
  always_comb begin
    w_stall_pc = 1'b0;
    w_bubble   = 1'b0;
    w_flush    = 1'b0;
    if (i_rst) begin
      if (i_mem_busy) begin
        w_stall_pc = 1'b1;
      end else if (i_ex_branch_taken) begin
        w_flush = 1'b1;
      end else begin
        case (r_state)
          RUN: begin
            w_stall_pc = w_lu;
            w_bubble   = w_lu;
          end
          LU_STALL: begin
            w_stall_pc = 1'b1;
            w_bubble   = 1'b1;
          end
          FLUSH:   w_flush = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= RUN;
      r_cnt       <= 3'd0;
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!i_mem_busy) begin
      if (i_ex_branch_taken) begin
        // Any state: a taken branch (re)starts the flush window.
        r_fwd_a <= 2'b00;
        r_fwd_b <= 2'b00;
        r_cnt   <= FL_RELOAD;
        r_state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else begin
        case (r_state)
          RUN: begin
            if (w_lu) begin
              r_fwd_a <= 2'b00;
              r_fwd_b <= 2'b00;
              r_cnt   <= LS_RELOAD;
              if (LOAD_STALL_CYCLES > 1) r_state <= LU_STALL;
              if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
              r_fwd_a <= w_sel_a;
              r_fwd_b <= w_sel_b;
            end
          end
          LU_STALL: begin
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
            r_cnt   <= r_cnt - 3'd1;
            if (r_cnt <= 3'd1) r_state <= RUN;
            if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
          end
          FLUSH: begin
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
            r_cnt   <= r_cnt - 3'd1;
            if (r_cnt <= 3'd1) r_state <= RUN;
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

  assign o_forwardA     = r_fwd_a;
  assign o_forwardB     = r_fwd_b;
  assign o_stall_pc     = w_stall_pc;
  assign o_bubble_id_ex = w_bubble;
  assign o_flush_if_id  = w_flush;
  assign o_flush_id_ex  = w_flush;
  assign o_stall_cnt    = r_stall_cnt;
  assign o_flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

  // Two instances: defaults, and a long-stall/long-flush/narrow-counter build.
  localparam int LC1 = 3, FC1 = 2;

  logic clk = 1'b0;
  logic rst, mem_busy, br;
  logic [4:0] rs1, rs2, ex_rd, mem_rd;
  logic use1, use2, ex_rw, ex_mr, mem_rw;

  logic [1:0]  fa [2];
  logic [1:0]  fb [2];
  logic        st [2];
  logic        bu [2];
  logic        fi [2];
  logic        fe [2];
  logic [15:0] sc0, fc0;
  logic [1:0]  sc1, fc1;

  int n_chk = 0, n_fail = 0;
  bit mdl_on = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_mem_busy(mem_busy),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_ex_rd(ex_rd), .i_ex_regwrite(ex_rw), .i_ex_memread(ex_mr),
    .i_mem_rd(mem_rd), .i_mem_regwrite(mem_rw), .i_ex_branch_taken(br),
    .o_forwardA(fa[0]), .o_forwardB(fb[0]), .o_stall_pc(st[0]), .o_bubble_id_ex(bu[0]),
    .o_flush_if_id(fi[0]), .o_flush_id_ex(fe[0]), .o_stall_cnt(sc0), .o_flush_cnt(fc0));

  hazard_fwd_ctrl #(.LOAD_STALL_CYCLES(LC1), .FLUSH_CYCLES(FC1), .CNT_W(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_mem_busy(mem_busy),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_ex_rd(ex_rd), .i_ex_regwrite(ex_rw), .i_ex_memread(ex_mr),
    .i_mem_rd(mem_rd), .i_mem_regwrite(mem_rw), .i_ex_branch_taken(br),
    .o_forwardA(fa[1]), .o_forwardB(fb[1]), .o_stall_pc(st[1]), .o_bubble_id_ex(bu[1]),
    .o_flush_if_id(fi[1]), .o_flush_id_ex(fe[1]), .o_stall_cnt(sc1), .o_flush_cnt(fc1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending work is kept as plain "bubbles left" / "flush cycles left" counts.
  int         m_sl [2], m_fl [2], m_sc [2], m_fc [2];
  logic [1:0] m_fa [2], m_fb [2];

  function automatic int lcyc(int d); return d ? LC1 : 1; endfunction
  function automatic int fcyc(int d); return d ? FC1 : 1; endfunction
  function automatic int cmax(int d); return d ? 3 : 65535; endfunction

  function automatic logic [1:0] m_sel(logic [4:0] rs, logic u);
    if (u && ex_rw && !ex_mr && ex_rd != 0 && ex_rd == rs) return 2'b10;
    if (u && mem_rw && mem_rd != 0 && mem_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_lu();
    return ex_mr && ex_rd != 0 && ((use1 && ex_rd == rs1) || (use2 && ex_rd == rs2));
  endfunction

  always @(negedge clk) begin
    if (mdl_on) begin
      for (int d = 0; d < 2; d++) begin
        bit es, eb, ef;
        es = 0; eb = 0; ef = 0;
        if (rst) begin
          if (mem_busy) es = 1;
          else if (br || m_fl[d] > 0) ef = 1;
          else if (m_sl[d] > 0 || m_lu()) begin es = 1; eb = 1; end
        end
        chk($sformatf("m%0d.stall_pc", d), 32'(st[d]), 32'(es));
        chk($sformatf("m%0d.bubble", d), 32'(bu[d]), 32'(eb));
        chk($sformatf("m%0d.flush_if_id", d), 32'(fi[d]), 32'(ef));
        chk($sformatf("m%0d.flush_id_ex", d), 32'(fe[d]), 32'(ef));
        chk($sformatf("m%0d.fwdA", d), 32'(fa[d]), 32'(m_fa[d]));
        chk($sformatf("m%0d.fwdB", d), 32'(fb[d]), 32'(m_fb[d]));
        chk($sformatf("m%0d.stall_cnt", d), d ? 32'(sc1) : 32'(sc0), 32'(m_sc[d]));
        chk($sformatf("m%0d.flush_cnt", d), d ? 32'(fc1) : 32'(fc0), 32'(m_fc[d]));
      end
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_sl[d] = 0; m_fl[d] = 0; m_sc[d] = 0; m_fc[d] = 0; m_fa[d] = 0; m_fb[d] = 0;
      end else if (!mem_busy) begin
        if (br) begin
          m_fa[d] = 0; m_fb[d] = 0; m_sl[d] = 0; m_fl[d] = fcyc(d) - 1;
          if (m_fc[d] < cmax(d)) m_fc[d]++;
        end else if (m_fl[d] > 0) begin
          m_fa[d] = 0; m_fb[d] = 0; m_fl[d]--;
        end else if (m_sl[d] > 0 || m_lu()) begin
          m_sl[d] = (m_sl[d] > 0) ? m_sl[d] - 1 : lcyc(d) - 1;
          m_fa[d] = 0; m_fb[d] = 0;
          if (m_sc[d] < cmax(d)) m_sc[d]++;
        end else begin
          m_fa[d] = m_sel(rs1, use1); m_fb[d] = m_sel(rs2, use2);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    mem_busy = 0; br = 0; rs1 = 0; rs2 = 0; use1 = 0; use2 = 0;
    ex_rd = 0; ex_rw = 0; ex_mr = 0; mem_rd = 0; mem_rw = 0;
  endtask

  task automatic set_lu();
    idle(); ex_mr = 1; ex_rw = 1; ex_rd = 3; rs1 = 3; use1 = 1;
  endtask

  task automatic do_reset();
    idle(); rst = 0; tick(); tick(); rst = 1;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2; logic u1, u2;
    logic [4:0] erd; logic erw, emr;
    logic [4:0] mrd; logic mrw;
    logic [1:0] efa, efb; logic est;
  } vec_t;

  vec_t tbl [9];

  initial begin
    //            rs1 rs2 u1 u2 erd erw emr mrd mrw  fa     fb    stall
    tbl[0] = '{5,  0,  1, 1, 5,  1,  0,  0,  0, 2'b10, 2'b00, 0};  // EX forward A
    tbl[1] = '{1,  7,  1, 1, 7,  1,  0,  7,  1, 2'b00, 2'b10, 0};  // EX beats MEM
    tbl[2] = '{0,  0,  1, 1, 0,  1,  0,  0,  1, 2'b00, 2'b00, 0};  // x0 never forwards
    tbl[3] = '{9,  2,  1, 1, 4,  1,  0,  9,  1, 2'b01, 2'b00, 0};  // MEM forward
    tbl[4] = '{9,  2,  0, 1, 4,  1,  0,  9,  1, 2'b00, 2'b00, 0};  // unused source
    tbl[5] = '{6,  8,  1, 1, 6,  1,  1,  8,  1, 2'b00, 2'b00, 1};  // load-use stalls
    tbl[6] = '{3,  6,  1, 0, 6,  1,  1,  3,  1, 2'b01, 2'b00, 0};  // load rd on unused rs2
    tbl[7] = '{12, 12, 1, 1, 12, 1,  0,  0,  0, 2'b10, 2'b10, 0};  // both from EX
    tbl[8] = '{12, 12, 1, 1, 12, 0,  0,  12, 1, 2'b01, 2'b01, 0};  // no EX write

    rst = 0; idle();
    tick(); tick();
    mdl_on = 1;
    // Controls are forced low while in reset, even with events present.
    set_lu(); br = 1;
    @(negedge clk);
    chk("rst.flush", 32'(fi[0]), 0);
    chk("rst.stall", 32'(st[1]), 0);
    tick();
    idle(); rst = 1;
    @(negedge clk);
    chk("rst.fwdA", 32'(fa[0]), 0);
    chk("rst.stall_cnt", 32'(sc0), 0);
    tick();

    // Table vectors on the default instance, each from a clean RUN state.
    foreach (tbl[i]) begin
      do_reset();
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; use1 = tbl[i].u1; use2 = tbl[i].u2;
      ex_rd = tbl[i].erd; ex_rw = tbl[i].erw; ex_mr = tbl[i].emr;
      mem_rd = tbl[i].mrd; mem_rw = tbl[i].mrw;
      @(negedge clk);
      chk($sformatf("vec%0d.stall", i), 32'(st[0]), 32'(tbl[i].est));
      tick(); idle();
      @(negedge clk);
      chk($sformatf("vec%0d.fwdA", i), 32'(fa[0]), 32'(tbl[i].efa));
      chk($sformatf("vec%0d.fwdB", i), 32'(fb[0]), 32'(tbl[i].efb));
      tick();
    end

    // Load-use then MEM forward of the loaded value.
    do_reset();
    set_lu();
    @(negedge clk);
    chk("lu.stall", 32'(st[0]), 1);
    chk("lu.bubble", 32'(bu[0]), 1);
    tick();
    idle(); mem_rd = 3; mem_rw = 1; rs1 = 3; use1 = 1;
    @(negedge clk);
    chk("lu.release", 32'(st[0]), 0);
    chk("lu.cnt", 32'(sc0), 1);
    tick(); idle();
    @(negedge clk);
    chk("lu.fwdA", 32'(fa[0]), 2'b01);
    tick();

    // Branch beats load-use, two-cycle flush.
    do_reset();
    set_lu(); br = 1;
    @(negedge clk);
    chk("br.flush1", 32'(fi[1]), 1);
    chk("br.nostall1", 32'(st[1]), 0);
    tick(); br = 0;
    @(negedge clk);
    chk("br.flush2", 32'(fe[1]), 1);
    chk("br.nostall2", 32'(st[1]), 0);
    tick(); idle();
    @(negedge clk);
    chk("br.flush_end", 32'(fi[1]), 0);
    chk("br.flush_cnt", 32'(fc1), 1);
    chk("br.stall_cnt", 32'(sc1), 0);
    tick();

    // mem_busy in the middle of a three-bubble stall.
    do_reset();
    set_lu();
    tick(); idle();
    @(negedge clk);
    chk("mb.bub2", 32'(bu[1]), 1);
    tick(); mem_busy = 1;
    repeat (3) begin
      @(negedge clk);
      chk("mb.freeze_stall", 32'(st[1]), 1);
      chk("mb.freeze_bub", 32'(bu[1]), 0);
      chk("mb.freeze_cnt", 32'(sc1), 2);
      tick();
    end
    mem_busy = 0;
    @(negedge clk);
    chk("mb.bub3", 32'(bu[1]), 1);
    tick();
    @(negedge clk);
    chk("mb.done", 32'(bu[1]), 0);
    chk("mb.total", 32'(sc1), 3);
    tick();

    // Reset in the middle of a flush, then counter saturation.
    do_reset();
    br = 1;
    tick(); br = 0; rst = 0;
    @(negedge clk);
    chk("rstf.comb", 32'(fi[1]), 0);
    tick(); rst = 1;
    @(negedge clk);
    chk("rstf.after", 32'(fe[1]), 0);
    chk("rstf.fcnt", 32'(fc1), 0);
    tick();
    set_lu(); repeat (6) tick();
    idle(); repeat (3) tick();
    br = 1; repeat (5) tick();
    idle(); repeat (2) tick();
    @(negedge clk);
    chk("sat.stall1", 32'(sc1), 3);
    chk("sat.stall0", 32'(sc0), 6);
    chk("sat.flush1", 32'(fc1), 3);
    chk("sat.flush0", 32'(fc0), 5);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 59) != 0);
      mem_busy = ($urandom_range(0, 6) == 0);
      br       = ($urandom_range(0, 9) == 0);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      use1 = 1'($urandom); use2 = 1'($urandom);
      ex_rw = 1'($urandom); ex_mr = ($urandom_range(0, 3) == 0);
      mem_rw = 1'($urandom);
      tick();
    end
    idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
